// File: rtl/uart_gpio_wrapper.sv
// uart_gpio_wrapper: UART program loader into instruction memory, then sensor-driven alarm GPIO
module uart_gpio_wrapper #(
  parameter int CLK_HZ    = 50000000,
  parameter int BIT_RATE  = 9600,
  parameter int MEM_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  input  logic [1:0] input_gpio_pins,
  output logic       uart_rx_break,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data,
  output logic [1:0] output_gpio_pins,
  output logic       write_done
);
  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(MEM_WORDS + 1);
  localparam int IW   = $clog2(MEM_WORDS);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          sampled;
  logic          bit_end;
  logic [1:0]    byte_cnt;
  logic [23:0]   word;
  logic [31:0]   full;
  logic [AW-1:0] addr;
  logic          mark;
  logic          store;
  logic [1:0]    sync1, sync2;
  logic [31:0]   mem [MEM_WORDS];
  logic          unused_bits;
  assign bit_end = cnt == CW'(CPB - 1);
  assign full = {uart_rx_data, word};
  assign store = uart_rx_valid && !write_done && byte_cnt == 2'd3;
  assign unused_bits = ^{sync2[0], mem[0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sampled <= 1'b0;
      uart_rx_data <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          bit_idx <= '0;
          sampled <= 1'b0;
          if (uart_rx_en && !uart_rxd) state <= START;
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            state <= uart_rxd ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            uart_rx_data <= {uart_rxd, uart_rx_data[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          // after the stop sample, linger until the line is idle again
          if (sampled) begin
            if (uart_rxd) state <= IDLE;
          end else if (bit_end) begin
            sampled <= 1'b1;
            uart_rx_valid <= uart_rxd;
            uart_rx_break <= !uart_rxd && uart_rx_data == 8'h00;
          end else cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word <= '0;
      addr <= '0;
      mark <= 1'b0;
      write_done <= 1'b0;
    end else begin
      mark <= 1'b0;
      write_done <= write_done | mark;
      if (uart_rx_valid && !write_done) begin
        if (byte_cnt == 2'd3) begin
          mark <= &full;
          if (addr != AW'(MEM_WORDS)) addr <= addr + 1'b1;
        end else word[8*byte_cnt +: 8] <= uart_rx_data;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (store && addr != AW'(MEM_WORDS)) mem[addr[IW-1:0]] <= full;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      output_gpio_pins <= '0;
    end else begin
      sync1 <= input_gpio_pins;
      sync2 <= sync1;
      output_gpio_pins <= write_done ? {2{sync2[1]}} : 2'b00;
    end
  end
endmodule

// File: tb/tb_uart_gpio_wrapper.sv
// tb_uart_gpio_wrapper: directed bench for the UART loader and alarm GPIO, scaled to 16 clocks per bit
module tb_uart_gpio_wrapper;
  localparam int CPB = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic [1:0] input_gpio_pins = 2'b00;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic [1:0] output_gpio_pins;
  logic       write_done;
  int errors = 0;
  int checks = 0;
  int nv = 0;
  int nb = 0;
  int ev = 0;

  uart_gpio_wrapper #(.CLK_HZ(160), .BIT_RATE(10), .MEM_WORDS(64)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rxd(uart_rxd),
    .uart_rx_en(uart_rx_en),
    .input_gpio_pins(input_gpio_pins),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .output_gpio_pins(output_gpio_pins),
    .write_done(write_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uart_rx_valid) nv++;
    if (uart_rx_break) nb++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_data(input logic [7:0] b);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_data(b);
    uart_rxd = stop;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(5);
    check("rst_valid", 32'(uart_rx_valid), 32'd0);
    check("rst_break", 32'(uart_rx_break), 32'd0);
    check("rst_data", 32'(uart_rx_data), 32'h00);
    check("rst_gpio", 32'(output_gpio_pins), 32'd0);
    check("rst_done", 32'(write_done), 32'd0);
    rst = 1'b0;
    uart_rx_en = 1'b1;
    input_gpio_pins = 2'b10;
    tick(3);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h55, 1'b1);
    ev += 2;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_data(8'h13);
    uart_rxd = 1'b1;
    tick(2);
    check("stop_data", 32'(uart_rx_data), 32'h13);
    check("stop_no_valid_yet", 32'(nv), 32'(ev));
    tick(CPB);
    ev++;
    check("byte_valid_once", 32'(nv), 32'(ev));
    send_frame(8'h01, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'hFD, 1'b1);
    ev += 3;
    tick(2);
    check("mem0", dut.mem[0], 32'hFD010113);
    check("done_after_w0", 32'(write_done), 32'd0);
    check("gpio_before_done", 32'(output_gpio_pins), 32'd0);
    send_frame(8'h23, 1'b1);
    send_frame(8'h26, 1'b1);
    ev += 2;
    send_frame(8'h00, 1'b0);
    check("break_pulse", 32'(nb), 32'd1);
    check("break_no_valid", 32'(nv), 32'(ev));
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(40);
    check("glitch_nb", 32'(nb), 32'd1);
    check("glitch_nv", 32'(nv), 32'(ev));
    check("glitch_data", 32'(uart_rx_data), 32'h00);
    send_frame(8'h5A, 1'b0);
    check("frame_err_nv", 32'(nv), 32'(ev));
    check("frame_err_nb", 32'(nb), 32'd1);
    send_frame(8'h81, 1'b1);
    send_frame(8'h02, 1'b1);
    ev += 2;
    tick(2);
    check("mem1", dut.mem[1], 32'h02812623);
    check("done_after_w1", 32'(write_done), 32'd0);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    ev += 3;
    send_data(8'hFF);
    uart_rxd = 1'b1;
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk);
      if (uart_rx_valid) break;
    end
    ev++;
    check("marker_valid_seen", 32'(uart_rx_valid), 32'd1);
    check("done_at_pulse", 32'(write_done), 32'd0);
    @(posedge clk);
    #1;
    check("mem2_marker", dut.mem[2], 32'hFFFFFFFF);
    check("done_at_write", 32'(write_done), 32'd0);
    @(posedge clk);
    #1;
    check("done_rise", 32'(write_done), 32'd1);
    check("gpio_lag", 32'(output_gpio_pins), 32'd0);
    tick(1);
    check("gpio_alarm", 32'(output_gpio_pins), 32'b11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    ev += 4;
    check("post_done_nv", 32'(nv), 32'(ev));
    check("post_done_data", 32'(uart_rx_data), 32'h44);
    check("post_done_addr", 32'(dut.addr), 32'd3);
    checks++;
    assert (dut.mem[3] !== 32'h44332211) else begin
      errors++;
      $error("FAIL post_done_mem3: got %h expected anything but 44332211", dut.mem[3]);
    end
    check("done_sticky", 32'(write_done), 32'd1);
    input_gpio_pins = 2'b01;
    tick(2);
    check("gpio_hold_2cyc", 32'(output_gpio_pins), 32'b11);
    tick(1);
    check("gpio_clear_3cyc", 32'(output_gpio_pins), 32'b00);
    input_gpio_pins = 2'b10;
    tick(3);
    check("gpio_set_3cyc", 32'(output_gpio_pins), 32'b11);
    uart_rx_en = 1'b0;
    send_frame(8'h77, 1'b1);
    check("en_low_nv", 32'(nv), 32'(ev));
    check("en_low_data", 32'(uart_rx_data), 32'h44);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
